// File: rtl/master_out_port_if.sv
// Bus between the master core, master_out_port and the slave input port.
// The master modport is the serializer's view: it receives the
// core-side request and the slave's ready signal. It drives the valid
// request, the two serial lines and the status flags.
interface master_out_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  write_mode;
    logic [ADDR_WIDTH-1:0] address_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  slave_ready;

    logic                  master_valid;
    logic                  tx_address;
    logic                  tx_data;
    logic                  write_en;
    logic                  read_en;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        input  start, write_mode, address_in, data_in, slave_ready,
        output master_valid, tx_address, tx_data, write_en, read_en, tx_busy, tx_done
    );

    modport slave (
        output start, write_mode, address_in, data_in, slave_ready,
        input  master_valid, tx_address, tx_data, write_en, read_en, tx_busy, tx_done
    );
endinterface

// File: rtl/master_out_port.sv
// Master-side serializer. It latches an address/data request, runs a
// valid/ready handshake with the slave, and shifts both words out
// LSB-first, one bit per clock. A one-cycle done pulse follows the
// last bit. Every output is decoded only from flops, so no path runs
// from an input straight to an output.
module master_out_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    master_out_port_if.master bus
);
    localparam int CNT_W  = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int DIDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_WIDTH - 1);
    // One bit wider than the counter, so the limit fits when DATA_WIDTH == ADDR_WIDTH.
    localparam logic [CNT_W:0]   DATA_LIM = (CNT_W + 1)'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_q, wr_d;

    // State, bit counter and shadow registers.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the shadow registers are reset as well, so the serial lines read 0 right after reset.
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    // Next state: accept in IDLE, handshake in REQ, count bits in SEND.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a value unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.address_in;
                    data_d  = bus.data_in;
                    wr_d    = bus.write_mode;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.slave_ready) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state, counter and shadow registers.
    always_comb begin
        bus.master_valid = (state_q == REQ);
        bus.tx_busy      = (state_q != IDLE);
        bus.tx_done      = (state_q == DONE);
        bus.write_en     = (state_q != IDLE) && wr_q;
        bus.read_en      = (state_q != IDLE) && !wr_q;
        bus.tx_address   = 1'b0;
        bus.tx_data      = 1'b0;
        if (state_q == SEND) begin
            bus.tx_address = addr_q[cnt_q];
            // Data line carries only DATA_WIDTH bits of a write; otherwise it stays 0.
            if (wr_q && ({1'b0, cnt_q} < DATA_LIM)) begin
                bus.tx_data = data_q[cnt_q[DIDX_W-1:0]];
            end
        end
    end
endmodule
